uart_tx_fsm: RTL and testbench

UART_TX_FSM -- requirements
Module: uart_tx_fsm

---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/uart_tx_parity.sv | 21 ++
 rtl/uart_tx_fsm.sv | 105 ++++++++++
 tb/tb_uart_tx_fsm.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART transmitter definitions: frame states and line-mux source encodings.
// The downstream line mux decodes mux_sel with these same constants.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] MUX_START  = 2'b00;
    localparam logic [1:0] MUX_STOP   = 2'b01;
    localparam logic [1:0] MUX_DATA   = 2'b10;
    localparam logic [1:0] MUX_PARITY = 2'b11;

endpackage

// File: rtl/uart_tx_parity.sv
// Parity of a payload word; odd=0 gives even parity (plain XOR), odd=1 inverts it.
module uart_tx_parity #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] word,
    input  logic             odd,
    output logic             parity
);

    // Seeding the chain with the type bit folds the odd-parity inversion into the XOR.
    logic [WIDTH:0] chain;

    assign chain[0] = odd;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_xor
        assign chain[gi+1] = chain[gi] ^ word[gi];
    end

    assign parity = chain[WIDTH];

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit sequencer: latches a payload on acceptance and steps the line-source
// select through start, data (LSB first), optional parity and stop.
module uart_tx_fsm
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_t             state_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_en_reg;
    logic                  par_typ_reg;
    logic [CNT_W-1:0]      cnt_reg;

    // Parity is taken from the latched word, so it cannot move while a frame is in flight.
    uart_tx_parity #(
        .WIDTH (DATA_WIDTH)
    ) u_parity (
        .word   (data_reg),
        .odd    (par_typ_reg),
        .parity (par_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            mux_sel     <= MUX_STOP;
            busy        <= 1'b0;
            ser_data    <= 1'b0;
            cnt_reg     <= '0;
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= 1'b0;
        end else begin
            case (state_reg)
                // STOP doubles as an acceptance point so frames can run back to back.
                IDLE, STOP: begin
                    ser_data <= 1'b0;
                    if (data_valid) begin
                        state_reg   <= START;
                        mux_sel     <= MUX_START;
                        busy        <= 1'b1;
                        data_reg    <= p_data;
                        par_en_reg  <= par_en;
                        par_typ_reg <= par_typ;
                    end else begin
                        state_reg <= IDLE;
                        mux_sel   <= MUX_STOP;
                        busy      <= 1'b0;
                    end
                end

                START: begin
                    state_reg <= DATA;
                    mux_sel   <= MUX_DATA;
                    cnt_reg   <= '0;
                    ser_data  <= data_reg[0];
                end

                DATA: begin
                    if (cnt_reg == LAST_BIT) begin
                        ser_data <= 1'b0;
                        if (par_en_reg) begin
                            state_reg <= PARITY;
                            mux_sel   <= MUX_PARITY;
                        end else begin
                            state_reg <= STOP;
                            mux_sel   <= MUX_STOP;
                        end
                    end else begin
                        cnt_reg  <= cnt_reg + 1'b1;
                        ser_data <= data_reg[cnt_reg + 1'b1];
                    end
                end

                PARITY: begin
                    state_reg <= STOP;
                    mux_sel   <= MUX_STOP;
                end

                default: begin
                    state_reg <= IDLE;
                    mux_sel   <= MUX_STOP;
                    busy      <= 1'b0;
                    ser_data  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: a per-cycle frame model plus directed frames with literal expectations.
module tb_uart_tx_fsm;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] p_data = '0;
    logic          data_valid = 1'b0;
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic [1:0]    mux_sel;
    logic          ser_data;
    logic          par_bit;
    logic          busy;

    int total = 0;
    int bad   = 0;

    uart_tx_fsm #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .mux_sel    (mux_sel),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // kind: 0 = idle/reset (may accept), 1 = mid-frame, 2 = stop (may accept)
    typedef struct {
        logic [1:0] mux;
        logic       bsy;
        logic       ser_chk;
        logic       ser;
        logic       par_chk;
        logic       par;
        int         kind;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    function automatic exp_t mk(input logic [1:0] m, input logic b, input logic sc,
                                input logic s, input logic pc, input logic p, input int k);
        exp_t e;
        e.mux = m; e.bsy = b; e.ser_chk = sc; e.ser = s;
        e.par_chk = pc; e.par = p; e.kind = k;
        return e;
    endfunction

    // One expected entry per line cycle of a whole frame.
    task automatic push_frame(input logic [DW-1:0] w, input logic pe, input logic pt);
        logic p;
        p = (^w) ^ pt;
        q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, p, 1));
        for (int k = 0; k < DW; k++)
            q.push_back(mk(2'b10, 1'b1, 1'b1, w[k], 1'b1, p, 1));
        if (pe)
            q.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, 1'b1, p, 1));
        q.push_back(mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b1, p, 2));
    endtask

    initial cur = mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            cur = mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        end else begin
            if (cur.kind != 1 && data_valid)
                push_frame(p_data, par_en, par_typ);
            if (q.size() > 0)
                cur = q.pop_front();
            else
                cur = mk(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        end
    end

    always @(negedge clk) begin
        chk("model_mux_sel", {30'd0, mux_sel}, {30'd0, cur.mux});
        chk("model_busy", {31'd0, busy}, {31'd0, cur.bsy});
        if (cur.ser_chk)
            chk("model_ser_data", {31'd0, ser_data}, {31'd0, cur.ser});
        if (cur.par_chk)
            chk("model_par_bit", {31'd0, par_bit}, {31'd0, cur.par});
    end

    logic [1:0] o_mux [32];
    logic       o_busy[32];
    logic       o_ser [32];
    logic       o_par [32];

    task automatic take(input int i);
        o_mux[i]  = mux_sel;
        o_busy[i] = busy;
        o_ser[i]  = ser_data;
        o_par[i]  = par_bit;
    endtask

    function automatic int busy_count(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) c += int'(o_busy[i]);
        return c;
    endfunction

    function automatic int data_mux_count(input int first);
        int c;
        c = 0;
        for (int i = first; i < first + DW; i++) c += (o_mux[i] == 2'b10) ? 1 : 0;
        return c;
    endfunction

    function automatic logic [DW-1:0] ser_word(input int first);
        logic [DW-1:0] w;
        for (int k = 0; k < DW; k++) w[k] = o_ser[first + k];
        return w;
    endfunction

    // Called right after a falling edge; sample 0 is the START cycle.
    task automatic run_frame(input logic [DW-1:0] w, input logic pe, input logic pt, input int n);
        p_data = w; par_en = pe; par_typ = pt; data_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            take(i);
            if (i == 0) data_valid = 1'b0;
        end
        $display("frame data=%02h par_en=%0d par_typ=%0d cycles_sampled=%0d", w, pe, pt, n);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_mux_sel", {30'd0, mux_sel}, 32'h1);
        chk("reset_busy", {31'd0, busy}, 32'h0);
        chk("reset_ser_data", {31'd0, ser_data}, 32'h0);
        chk("reset_par_bit", {31'd0, par_bit}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(8'hA5, 1'b0, 1'b0, 12);
        chk("a5_start_mux", {30'd0, o_mux[0]}, 32'h0);
        chk("a5_data_mux_cycles", data_mux_count(1), 8);
        chk("a5_stop_mux", {30'd0, o_mux[9]}, 32'h1);
        chk("a5_ser_bits", {24'd0, ser_word(1)}, 32'hA5);
        chk("a5_busy_cycles", busy_count(12), 10);
        chk("a5_idle_busy", {31'd0, o_busy[10]}, 32'h0);

        run_frame(8'hA5, 1'b1, 1'b0, 13);
        chk("a5_even_parity_mux", {30'd0, o_mux[9]}, 32'h3);
        chk("a5_even_stop_mux", {30'd0, o_mux[10]}, 32'h1);
        chk("a5_even_busy_cycles", busy_count(13), 11);
        chk("a5_even_par_bit", {31'd0, o_par[9]}, 32'h0);

        run_frame(8'hA5, 1'b1, 1'b1, 13);
        chk("a5_odd_par_bit_start", {31'd0, o_par[0]}, 32'h1);
        chk("a5_odd_par_bit_stop", {31'd0, o_par[10]}, 32'h1);
        chk("a5_odd_busy_cycles", busy_count(13), 11);

        // Back to back: valid held from the first request through the first STOP.
        p_data = 8'h01; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            take(i);
            if (i == 0) p_data = 8'hFF;
            if (i == 10) data_valid = 1'b0;
        end
        $display("frame data=01 then FF back-to-back cycles_sampled=22");
        chk("b2b_first_ser", {24'd0, ser_word(1)}, 32'h01);
        chk("b2b_second_start_mux", {30'd0, o_mux[10]}, 32'h0);
        chk("b2b_second_ser", {24'd0, ser_word(11)}, 32'hFF);
        chk("b2b_busy_cycles", busy_count(20), 20);
        chk("b2b_final_idle", {31'd0, o_busy[20]}, 32'h0);

        // A request during DATA bit 3 must be ignored entirely.
        p_data = 8'h3C; data_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            take(i);
            if (i == 0) data_valid = 1'b0;
            if (i == 4) begin p_data = 8'h00; data_valid = 1'b1; end
            if (i == 5) data_valid = 1'b0;
        end
        $display("frame data=3C with ignored request during DATA bit 3");
        chk("ign_ser_bits", {24'd0, ser_word(1)}, 32'h3C);
        chk("ign_busy_cycles", busy_count(12), 10);
        chk("ign_idle_mux", {30'd0, o_mux[10]}, 32'h1);

        // Asynchronous abort during DATA bit 4.
        p_data = 8'hC3; data_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            take(i);
            if (i == 0) data_valid = 1'b0;
        end
        chk("abort_bit4_ser", {31'd0, o_ser[5]}, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("abort_mux_sel", {30'd0, mux_sel}, 32'h1);
        chk("abort_busy", {31'd0, busy}, 32'h0);
        chk("abort_ser_data", {31'd0, ser_data}, 32'h0);
        $display("frame data=C3 aborted by reset during DATA bit 4");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_frame(8'h55, 1'b0, 1'b0, 12);
        chk("post_reset_start_mux", {30'd0, o_mux[0]}, 32'h0);
        chk("post_reset_ser_bits", {24'd0, ser_word(1)}, 32'h55);
        chk("post_reset_busy_cycles", busy_count(12), 10);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
